// File: rtl/operand_entry_8_bits.sv
// operand_entry_8_bits: builds an 8-bit adder operand from two debounced nibble entries
// Optional feature macro: NIBBLE_PREVIEW_EN (adds the preview output)
// Ports:
//   clk        system clock, all state on rising edge
//   areset     asynchronous reset, active-low
//   sw[3:0]    nibble switches, sampled only in the capture cycle
//   key_n      entry button, active-low, bouncy
//   clr_n      clear button, active-low, bouncy
//   value[7:0] last completed operand {hi, lo}, held between entries
//   valid      one-cycle pulse in the cycle value updates
//   lo_pending high nibble captured, waiting for the low nibble
//   preview    (NIBBLE_PREVIEW_EN only) byte being composed
module operand_entry_8_bits #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [3:0] sw,
    input  logic       key_n,
    input  logic       clr_n,
    output logic [7:0] value,
    output logic       valid,
    output logic       lo_pending
`ifdef NIBBLE_PREVIEW_EN
    ,
    output logic [7:0] preview
`endif
);
    typedef enum logic {S_HI, S_LO} state_t;
    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    // bit 0 = key, bit 1 = clear
    logic [1:0] sync1, sync2, db, db_q, press;
    logic [DB_CNT_W-1:0] cnt [2];
    state_t state, state_d;
    logic [3:0] hi_reg, hi_d;
    logic [7:0] value_d;
    logic valid_d;
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            db_q  <= 2'b11;
        end else begin
            sync1 <= {clr_n, key_n};
            sync2 <= sync1;
            db_q  <= db;
        end
    end
    for (genvar b = 0; b < 2; b++) begin : g_db
        // a level change is accepted only after LAST+1 consecutive differing samples
        always_ff @(posedge clk or negedge areset) begin
            if (!areset) begin
                db[b]  <= 1'b1;
                cnt[b] <= '0;
            end else if (sync2[b] == db[b]) begin
                cnt[b] <= '0;
            end else if (cnt[b] == LAST) begin
                db[b]  <= sync2[b];
                cnt[b] <= '0;
            end else begin
                cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end
    assign press = db_q & ~db;
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state  <= S_HI;
            hi_reg <= 4'h0;
            value  <= 8'h00;
            valid  <= 1'b0;
        end else begin
            state  <= state_d;
            hi_reg <= hi_d;
            value  <= value_d;
            valid  <= valid_d;
        end
    end
    // clear has priority over a simultaneous key press
    always_comb begin
        state_d = state;
        hi_d    = hi_reg;
        value_d = value;
        valid_d = 1'b0;
        if (press[1]) begin
            state_d = S_HI;
            hi_d    = 4'h0;
            value_d = 8'h00;
        end else if (press[0]) begin
            if (state == S_HI) begin
                hi_d    = sw;
                state_d = S_LO;
            end else begin
                value_d = {hi_reg, sw};
                valid_d = 1'b1;
                state_d = S_HI;
            end
        end
    end
    assign lo_pending = (state == S_LO);
`ifdef NIBBLE_PREVIEW_EN
    assign preview = {(state == S_LO) ? hi_reg : 4'h0, sw};
`endif
endmodule

// File: tb/tb_operand_entry_8_bits.sv
// tb_operand_entry_8_bits: scoreboard bench for operand_entry_8_bits
module tb_operand_entry_8_bits;
    localparam int N = 4;
    logic clk = 1'b0;
    logic areset = 1'b0;
    logic key_n = 1'b1;
    logic clr_n = 1'b1;
    logic [3:0] sw = 4'h0;
    logic [7:0] value;
    logic valid, lo_pending;
`ifdef NIBBLE_PREVIEW_EN
    logic [7:0] preview;
`endif
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    logic prev_valid = 1'b0;
    int lat;

    always #5 clk = ~clk;

    operand_entry_8_bits #(.DEBOUNCE_CYCLES(N), .DB_CNT_W(3)) dut (
        .clk(clk),
        .areset(areset),
        .sw(sw),
        .key_n(key_n),
        .clr_n(clr_n),
        .value(value),
        .valid(valid),
        .lo_pending(lo_pending)
`ifdef NIBBLE_PREVIEW_EN
        ,
        .preview(preview)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("valid_single_cycle", {31'd0, prev_valid}, 0);
            if (sb.size() == 0) check("unexpected_valid", {31'd0, valid}, 0);
            else check("value_on_valid", {24'd0, value}, {24'd0, sb.pop_front()});
        end
        prev_valid = valid;
    end

    task automatic press(input logic [3:0] s, input logic use_key, input logic use_clr, output int l);
        l = 0;
        @(negedge clk);
        sw = s;
        key_n = !use_key;
        clr_n = !use_clr;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid && l == 0) l = k;
        end
        @(negedge clk);
        key_n = 1'b1;
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic enter_byte(input logic [3:0] hi, input logic [3:0] lo);
        int l;
        press(hi, 1'b1, 1'b0, l);
        check("lo_pending_after_hi", {31'd0, lo_pending}, 1);
        check("no_valid_on_hi", l, 0);
`ifdef NIBBLE_PREVIEW_EN
        check("preview_s_lo", {24'd0, preview}, {24'd0, hi, hi});
`endif
        sb.push_back({hi, lo});
        press(lo, 1'b1, 1'b0, l);
        check("latency", l, N + 3);
        check("lo_pending_after_lo", {31'd0, lo_pending}, 0);
        check("value_hold", {24'd0, value}, {24'd0, hi, lo});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_value", {23'd0, value, valid}, 0);
        areset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {22'd0, value, valid, lo_pending}, 0);
        end
`ifdef NIBBLE_PREVIEW_EN
        sw = 4'h9;
        #1 check("preview_s_hi", {24'd0, preview}, 32'h09);
`endif
        enter_byte(4'hA, 4'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            key_n = 1'b0;
            repeat (2) @(negedge clk);
            key_n = 1'b1;
            repeat (1) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("bounce_lo_pending", {31'd0, lo_pending}, 0);
        check("bounce_value", {24'd0, value}, 32'hA5);
        press(4'hF, 1'b1, 1'b0, lat);
        check("clr_pre_lo_pending", {31'd0, lo_pending}, 1);
        press(4'h0, 1'b0, 1'b1, lat);
        check("clr_lo_pending", {31'd0, lo_pending}, 0);
        check("clr_value", {24'd0, value}, 0);
        check("clr_no_valid", lat, 0);
        enter_byte(4'h1, 4'h2);
        press(4'h7, 1'b1, 1'b0, lat);
        check("rst_pre_lo_pending", {31'd0, lo_pending}, 1);
        @(negedge clk);
        #2 areset = 1'b0;
        #1;
        check("rst_async_value", {24'd0, value}, 0);
        check("rst_async_lo_pending", {31'd0, lo_pending}, 0);
        @(negedge clk);
        areset = 1'b1;
        repeat (5) @(negedge clk);
        enter_byte(4'h3, 4'h4);
        press(4'hA, 1'b1, 1'b0, lat);
        check("both_pre_lo_pending", {31'd0, lo_pending}, 1);
        press(4'h5, 1'b1, 1'b1, lat);
        check("both_no_valid", lat, 0);
        check("both_lo_pending", {31'd0, lo_pending}, 0);
        check("both_value", {24'd0, value}, 0);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_entry_8_bits.md
Name: operand_entry_8_bits

Overview:
- Upstream operand source for the 8-bit A+B adder stage.
- Builds one 8-bit operand from four slide switches in two nibble-entry steps, using a debounced push button.
- Outputs: the operand on `value`, plus a one-cycle `valid` strobe when the byte is complete.
- `value` holds steady between entries. This keeps the adder's `in` stable while its internal register samples it.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a button level change (10 ms at 50 MHz).
- DB_CNT_W, 20, width of each debounce counter; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- areset, input, 1, asynchronous reset, active-low (0 = reset).
- sw, input, 4, nibble switches; asynchronous, sampled directly at the capture cycle.
- key_n, input, 1, entry push button, active-low, asynchronous, bouncy.
- clr_n, input, 1, clear push button, active-low, asynchronous, bouncy.
- value, output, 8, last completed operand {hi, lo}.
- valid, output, 1, one-cycle pulse in the cycle `value` updates.
- lo_pending, output, 1, 1 = high nibble captured, waiting for the low nibble.

Behaviour:
- Reset (areset=0, asynchronous):
  - value=8'h00, valid=0, lo_pending=0, state=S_HI, hi_reg=4'h0.
  - Synchronizer flops and debounced levels = 1 (released); debounce counters = 0.
- Synchronizer: key_n and clr_n each pass through 2 flops before any use.
- Debounce (identical, independent instance per button):
  - Synced level equal to the debounced level: counter cleared to 0.
  - Synced level differs: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: debounced level takes the synced level, counter clears.
  - Any return to the debounced level before that restarts the count. Bounces shorter than DEBOUNCE_CYCLES are ignored.
- Press detect: press pulse = registered debounced level 1 -> 0 transition. Exactly one pulse per press. Holding the button produces no repeat; release produces no pulse.
- FSM, 2 states:
  - S_HI (lo_pending=0): on key press, hi_reg<=sw, go to S_LO.
  - S_LO (lo_pending=1): on key press, value<={hi_reg, sw}, valid=1 for that one cycle, go to S_HI.
- Clear press, any state: go to S_HI, hi_reg<=0, value<=8'h00, valid=0.
- Key press and clear press in the same cycle: clear wins, key press is discarded.
- valid is registered and high for exactly 1 cycle per completed byte. It is never high two cycles in a row.
- Latency: valid rises exactly DEBOUNCE_CYCLES+3 rising clk edges after the first edge sampling key_n=0, provided key_n is held low throughout.
- sw is sampled only in the capture cycle; sw changes at any other time have no effect.
- Reset mid-entry (asynchronous): the partial high nibble is lost, FSM returns to S_HI, value returns to 0.

Optional Feature:
- Macro: NIBBLE_PREVIEW_EN.
- Defined: adds output port preview[7:0].
  - In S_HI, preview={4'h0, sw}.
  - In S_LO, preview={hi_reg, sw}.
  - Combinational from registered state and sw, so the board displays can show the byte being composed.
  - Reset value: {4'h0, sw}.
- Undefined: no preview port and no preview logic. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, DB_CNT_W=3):
- Release areset, idle 20 cycles -> value=8'h00, valid=0, lo_pending=0 throughout.
- sw=4'hA, press key_n for 10 cycles, release; then sw=4'h5, press again -> lo_pending=1 after the first press; after the second press valid pulses once (1 cycle, 7 edges after the key_n low sample) and value=8'hA5.
- Toggle key_n low for 2 cycles, 3 times, with 2-cycle highs between -> no press accepted; lo_pending and value unchanged.
- sw=4'hF, press key (lo_pending=1), then press clr_n -> lo_pending=0, value=8'h00; then enter 4'h1, 4'h2 -> value=8'h12.
- Assert areset low while lo_pending=1 and hi_reg=4'h7 -> immediate value=0, lo_pending=0; next entry 4'h3, 4'h4 -> value=8'h34.
- key_n and clr_n asserted on identical cycles from S_LO -> clear wins: value=8'h00, no valid, lo_pending=0.
